// File: rtl/serial_word_rx_pkg.sv
// Shared types and helpers for the serial word receiver and its bit timing.
package serial_word_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  function automatic int mid_point(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/serial_word_rx_bit_tick_gen.sv
// Bit-period divider: free-running modulo-DIV counter, held at zero by restart,
// with a mid-bit tick (first sample) and an end-of-period tick (later samples).
module bit_tick_gen
  import serial_word_rx_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic restart,
  output logic mid_tick,
  output logic bit_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] MID  = CW'(mid_point(DIV));
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (restart || (cnt_q == LAST)) cnt_d = '0;
    else                            cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign mid_tick = (cnt_q == MID);
  assign bit_tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_word_rx.sv
// Serial frame receiver: start, N data bits LSB-first, optional parity, stop;
// completed words are held on Q under a Valid/Ready handshake.
//
// state  | meaning
// IDLE   | line idle, divider held at 0, waiting for Sin=0
// START  | confirming start bit at mid-bit
// DATA   | shifting in N data bits
// PARITY | sampling parity bit, result held until STOP
// STOP   | checking stop bit, delivering word or raising an error
// BREAK  | line stuck low after framing error, waiting for Sin=1
module serial_word_rx
  import serial_word_rx_pkg::*;
#(
  parameter int N         = 4,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 1,
  parameter int ODD       = 0
) (
  input  logic         Clk,
  input  logic         Resetn,
  input  logic         Sin,
  input  logic         Ready,
  output logic [N-1:0] Q,
  output logic         Valid,
  output logic         ParErr,
  output logic         FrmErr,
  output logic         Overrun
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic ODD_B = (ODD != 0);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  q_q, q_d;
  logic          par_bad_q, par_bad_d;
  logic          valid_q, valid_d;
  logic          par_err_q, par_err_d;
  logic          frm_err_q, frm_err_d;
  logic          ovr_q, ovr_d;
  logic          restart, mid_tick, bit_tick;
  logic [N-1:0]  in_msb;

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk_sys  (Clk),
    .rst_b    (Resetn),
    .restart  (restart),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    q_d       = q_q;
    valid_d   = valid_q && !Ready;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
    ovr_d     = 1'b0;
    restart   = 1'b0;
    in_msb    = '0;
    in_msb[N-1] = Sin;

    case (state_q)
      IDLE: begin
        restart = 1'b1;
        if (!Sin) begin
          // With DIV=1 the divider sits on the mid point, so this is the start sample.
          if (mid_tick) begin
            state_d   = DATA;
            bit_d     = '0;
            par_bad_d = 1'b0;
          end else begin
            restart = 1'b0;
            state_d = START;
          end
        end
      end
      START: begin
        if (mid_tick) begin
          restart = 1'b1;
          if (Sin) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_d     = '0;
            par_bad_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = (shift_q >> 1) | in_msb;
          bit_d   = bit_q + CW'(1);
          if (bit_q == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          par_bad_d = (^shift_q) ^ Sin ^ ODD_B;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          if (!Sin) begin
            frm_err_d = 1'b1;
            state_d   = BREAK;
          end else if (par_bad_q) begin
            par_err_d = 1'b1;
          end else if (!valid_q || Ready) begin
            q_d     = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      BREAK: begin
        restart = 1'b1;
        if (Sin) state_d = IDLE;
      end
      default: begin
        restart = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      q_q       <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      q_q       <= q_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign Q       = q_q;
  assign Valid   = valid_q;
  assign ParErr  = par_err_q;
  assign FrmErr  = frm_err_q;
  assign Overrun = ovr_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: a DIV=1 instance for framing/handshake
// scenarios and a DIV=4 instance for glitch rejection and mid-bit latency.
module tb_serial_word_rx;

  logic       Clk = 1'b0;
  logic       Resetn;
  logic       Sin1, Sin4, Ready;
  logic [3:0] Q1, Q4;
  logic       Valid1, ParErr1, FrmErr1, Overrun1;
  logic       Valid4, ParErr4, FrmErr4, Overrun4;

  int n_pass = 0;
  int n_total = 0;

  serial_word_rx #(.N(4), .DIV(1), .PARITY_EN(1), .ODD(0)) dut1 (
    .Clk(Clk), .Resetn(Resetn), .Sin(Sin1), .Ready(Ready),
    .Q(Q1), .Valid(Valid1), .ParErr(ParErr1), .FrmErr(FrmErr1), .Overrun(Overrun1)
  );

  serial_word_rx #(.N(4), .DIV(4), .PARITY_EN(1), .ODD(0)) dut4 (
    .Clk(Clk), .Resetn(Resetn), .Sin(Sin4), .Ready(Ready),
    .Q(Q4), .Valid(Valid4), .ParErr(ParErr4), .FrmErr(FrmErr4), .Overrun(Overrun4)
  );

  always #5 Clk = ~Clk;

  // Called at a negedge; drives start, data LSB-first, parity, stop one bit per clock.
  // Returns at the negedge right after the stop-sample edge.
  task automatic frame1(input logic [3:0] d, input logic p, input logic stop, input logic rdy_stop);
    logic [6:0] bits;
    bits = {stop, p, d, 1'b0};
    for (int i = 0; i < 7; i++) begin
      Sin1 = bits[i];
      if (i == 6) Ready = rdy_stop;
      @(negedge Clk);
    end
    if (rdy_stop) Ready = 1'b0;
  endtask

  task automatic consume1();
    Ready = 1'b1;
    @(negedge Clk);
    Ready = 1'b0;
    n_total++; if (Valid1 !== 1'b0) $display("FAIL consume_valid got %b want 0", Valid1); else n_pass++;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Sin1 = 1'b1; Sin4 = 1'b1; Ready = 1'b0;
    repeat (3) @(negedge Clk);
    n_total++; if (Q1 !== 4'h0) $display("FAIL rst_q1 got %h want 0", Q1); else n_pass++;
    n_total++; if ({Valid1, ParErr1, FrmErr1, Overrun1} !== 4'b0000)
      $display("FAIL rst_flags1 got %b want 0000", {Valid1, ParErr1, FrmErr1, Overrun1}); else n_pass++;
    n_total++; if ({Q4, Valid4, ParErr4, FrmErr4, Overrun4} !== 8'h00)
      $display("FAIL rst_dut4 got %h want 00", {Q4, Valid4, ParErr4, FrmErr4, Overrun4}); else n_pass++;
    Resetn = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_good_frame();
    frame1(4'hB, 1'b1, 1'b1, 1'b0);
    n_total++; if (Q1 !== 4'hB) $display("FAIL good_q got %h want b", Q1); else n_pass++;
    n_total++; if ({Valid1, ParErr1, FrmErr1, Overrun1} !== 4'b1000)
      $display("FAIL good_flags got %b want 1000", {Valid1, ParErr1, FrmErr1, Overrun1}); else n_pass++;
    consume1();
  endtask

  task automatic test_parity_err();
    frame1(4'hB, 1'b0, 1'b1, 1'b0);
    n_total++; if (ParErr1 !== 1'b1) $display("FAIL par_pulse got %b want 1", ParErr1); else n_pass++;
    n_total++; if (Valid1 !== 1'b0) $display("FAIL par_valid got %b want 0", Valid1); else n_pass++;
    n_total++; if (Q1 !== 4'hB) $display("FAIL par_q_kept got %h want b", Q1); else n_pass++;
    @(negedge Clk);
    n_total++; if (ParErr1 !== 1'b0) $display("FAIL par_one_cycle got %b want 0", ParErr1); else n_pass++;
  endtask

  task automatic test_framing();
    int extra;
    extra = 0;
    frame1(4'h3, 1'b0, 1'b0, 1'b0);
    n_total++; if ({FrmErr1, ParErr1, Valid1} !== 3'b100)
      $display("FAIL frm_pulse got %b want 100", {FrmErr1, ParErr1, Valid1}); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk);
      if (FrmErr1 || ParErr1 || Valid1) extra++;
    end
    n_total++; if (extra !== 0) $display("FAIL frm_break_quiet got %0d want 0", extra); else n_pass++;
    Sin1 = 1'b1;
    repeat (2) @(negedge Clk);
    frame1(4'h3, 1'b0, 1'b1, 1'b0);
    n_total++; if ({Q1, Valid1, FrmErr1} !== 6'b0011_1_0)
      $display("FAIL frm_recover got q=%h v=%b f=%b want q=3 v=1 f=0", Q1, Valid1, FrmErr1); else n_pass++;
    consume1();
  endtask

  task automatic test_back_to_back();
    frame1(4'hA, 1'b0, 1'b1, 1'b0);
    n_total++; if ({Q1, Valid1, Overrun1} !== 6'b1010_1_0)
      $display("FAIL b2b_first got q=%h v=%b o=%b want q=a v=1 o=0", Q1, Valid1, Overrun1); else n_pass++;
    frame1(4'h5, 1'b0, 1'b1, 1'b0);
    n_total++; if ({Q1, Valid1, Overrun1} !== 6'b1010_1_1)
      $display("FAIL b2b_overrun got q=%h v=%b o=%b want q=a v=1 o=1", Q1, Valid1, Overrun1); else n_pass++;
    Ready = 1'b1;
    @(negedge Clk);
    Ready = 1'b0;
    n_total++; if ({Valid1, Overrun1} !== 2'b00)
      $display("FAIL b2b_drop got v=%b o=%b want v=0 o=0", Valid1, Overrun1); else n_pass++;
    frame1(4'h9, 1'b0, 1'b1, 1'b0);
    frame1(4'hC, 1'b0, 1'b1, 1'b1);
    n_total++; if ({Q1, Valid1, Overrun1} !== 6'b1100_1_0)
      $display("FAIL b2b_reload got q=%h v=%b o=%b want q=c v=1 o=0", Q1, Valid1, Overrun1); else n_pass++;
    consume1();
  endtask

  task automatic test_div4();
    int noise, e, first;
    logic [6:0] bits;
    noise = 0; e = 0; first = -1;
    Sin4 = 1'b0;
    @(negedge Clk);
    Sin4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Valid4 || ParErr4 || FrmErr4 || Overrun4) noise++;
    end
    n_total++; if (noise !== 0) $display("FAIL glitch_quiet got %0d want 0", noise); else n_pass++;
    bits = {1'b1, 1'b0, 4'h6, 1'b0};
    for (int b = 0; b < 7; b++) begin
      for (int c = 0; c < 4; c++) begin
        Sin4 = bits[b];
        @(negedge Clk);
        e++;
        if (Valid4 && first < 0) first = e - 1;
      end
    end
    n_total++; if (first !== 26) $display("FAIL div4_latency got %0d want 26", first); else n_pass++;
    n_total++; if ({Q4, ParErr4, FrmErr4} !== 6'b0110_0_0)
      $display("FAIL div4_q got q=%h p=%b f=%b want q=6 p=0 f=0", Q4, ParErr4, FrmErr4); else n_pass++;
  endtask

  task automatic test_reset_mid();
    frame1(4'h7, 1'b1, 1'b1, 1'b0);
    n_total++; if ({Q1, Valid1} !== 5'b0111_1)
      $display("FAIL pre_rst got q=%h v=%b want q=7 v=1", Q1, Valid1); else n_pass++;
    Sin1 = 1'b0; @(negedge Clk);
    Sin1 = 1'b1; @(negedge Clk);
    Sin1 = 1'b1; @(negedge Clk);
    #1 Resetn = 1'b0;
    #1;
    n_total++; if ({Q1, Valid1} !== 5'b0000_0)
      $display("FAIL async_rst1 got q=%h v=%b want q=0 v=0", Q1, Valid1); else n_pass++;
    n_total++; if ({Q4, Valid4} !== 5'b0000_0)
      $display("FAIL async_rst4 got q=%h v=%b want q=0 v=0", Q4, Valid4); else n_pass++;
    @(negedge Clk);
    Resetn = 1'b1;
    Sin1 = 1'b1;
    @(negedge Clk);
    frame1(4'h8, 1'b1, 1'b1, 1'b0);
    n_total++; if ({Q1, Valid1, ParErr1, FrmErr1, Overrun1} !== 8'b1000_1_000)
      $display("FAIL post_rst got q=%h flags=%b want q=8 flags=1000", Q1,
               {Valid1, ParErr1, FrmErr1, Overrun1}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_framing();
    test_back_to_back();
    test_div4();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
